// File: rtl/gauss_scan_ctrl_pkg.sv
// Shared types and constants for the Gaussian frame sequencer.
`timescale 1ns/1ps
package gauss_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        FILT,
        BRD_RD,
        BRD_WAIT,
        WRITE,
        DONE
    } state_e;

    localparam int WIN_TAPS        = 9;
    localparam int INTERIOR_CYCLES = 12;
    localparam int BORDER_CYCLES   = 3;

endpackage

// File: rtl/gauss_scan_ctrl_if.sv
// CPU control and pixel-RAM bus of the Gaussian frame sequencer.
`timescale 1ns/1ps
interface gauss_scan_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              start;
    logic [ADDR_W-1:0] src_base;
    logic [ADDR_W-1:0] dst_base;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    modport master (
        input  start, src_base, dst_base, rd_data,
        output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );

    modport slave (
        output start, src_base, dst_base, rd_data,
        input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/gauss_scan_ctrl_filter.sv
// 3x3 Gaussian kernel (1-2-1 / 2-4-2 / 1-2-1, sum >> 4), one register stage.
`timescale 1ns/1ps
module gaussian_filter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inicio,
    input  logic [DATA_W-1:0] pixel_00,
    input  logic [DATA_W-1:0] pixel_01,
    input  logic [DATA_W-1:0] pixel_02,
    input  logic [DATA_W-1:0] pixel_10,
    input  logic [DATA_W-1:0] pixel_11,
    input  logic [DATA_W-1:0] pixel_12,
    input  logic [DATA_W-1:0] pixel_20,
    input  logic [DATA_W-1:0] pixel_21,
    input  logic [DATA_W-1:0] pixel_22,
    output logic [DATA_W-1:0] pixel_procesado,
    output logic              listo
);
    localparam int SUM_W = DATA_W + 4;

    // Weights total 16, so the shift can never exceed DATA_W bits.
    function automatic logic [DATA_W-1:0] scale_sum(input logic [SUM_W-1:0] s);
        return DATA_W'(s >> 4);
    endfunction

    logic [SUM_W-1:0]  sum_p0;
    logic [DATA_W-1:0] pix_p0_d, pix_p0_q;
    logic              vld_p0_d, vld_p0_q;

    always_comb begin
        sum_p0 = SUM_W'(pixel_00)        + (SUM_W'(pixel_01) << 1) + SUM_W'(pixel_02)
               + (SUM_W'(pixel_10) << 1) + (SUM_W'(pixel_11) << 2) + (SUM_W'(pixel_12) << 1)
               + SUM_W'(pixel_20)        + (SUM_W'(pixel_21) << 1) + SUM_W'(pixel_22);
        pix_p0_d = inicio ? scale_sum(sum_p0) : pix_p0_q;
        vld_p0_d = inicio;
    end

    // Stage p0: weighted sum registered on inicio
    always_ff @(posedge clk) begin
        pix_p0_q <= pix_p0_d;
        if (rst) begin
            vld_p0_q <= 1'b0;
        end else begin
            vld_p0_q <= vld_p0_d;
        end
    end

    assign pixel_procesado = pix_p0_q;
    assign listo           = vld_p0_q;
endmodule

// File: rtl/gauss_scan_ctrl.sv
// Frame sequencer: walks the source image, feeds the Gaussian filter, writes the destination.
`timescale 1ns/1ps
module gauss_scan_ctrl
    import gauss_ctrl_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32
) (
    input  logic               clk,
    input  logic               rst,
    gauss_scan_ctrl_if.master  bus
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    typedef logic [ADDR_W-1:0] addr_t;

    function automatic addr_t pix_addr(input addr_t base, input addr_t px, input addr_t py);
        return base + py * addr_t'(IMG_W) + px;
    endfunction

    function automatic logic is_interior(input logic [XW-1:0] px, input logic [YW-1:0] py);
        return (px != '0) && (px != X_LAST) && (py != '0) && (py != Y_LAST);
    endfunction

    state_e        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [3:0]    k_q, k_d;
    addr_t         src_q, src_d, dst_q, dst_d;
    logic [7:0]    win_q [WIN_TAPS];
    logic [7:0]    win_d [WIN_TAPS];
    logic [7:0]    brd_q, brd_d;

    logic          busy, done, rd_en, wr_en, inicio;
    addr_t         rd_addr, wr_addr;
    logic [7:0]    wr_data;
    logic [7:0]    filt_pix;
    logic          filt_vld;
    logic          interior;
    addr_t         nb_x, nb_y;

    assign interior = is_interior(x_q, y_q);
    // Neighbour k sits at column k%3-1, row k/3-1 relative to the centre pixel.
    assign nb_x = addr_t'(x_q) + addr_t'(k_q % 4'd3) - addr_t'(1);
    assign nb_y = addr_t'(y_q) + addr_t'(k_q / 4'd3) - addr_t'(1);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        k_d     = k_q;
        src_d   = src_q;
        dst_d   = dst_q;
        win_d   = win_q;
        brd_d   = brd_q;
        rd_en   = 1'b0;
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        done    = 1'b0;
        inicio  = 1'b0;
        busy    = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    src_d   = bus.src_base;
                    dst_d   = bus.dst_base;
                    x_d     = '0;
                    y_d     = '0;
                    k_d     = '0;
                    state_d = BRD_RD;
                end
            end
            FETCH: begin
                rd_en   = 1'b1;
                rd_addr = pix_addr(src_q, nb_x, nb_y);
                // Read data lags the strobe by one cycle, so tap k-1 lands now.
                if (k_q != 4'd0) begin
                    win_d[k_q - 4'd1] = bus.rd_data;
                end
                k_d = k_q + 4'd1;
                if (k_q == 4'(WIN_TAPS - 1)) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                win_d[WIN_TAPS-1] = bus.rd_data;
                state_d           = FILT;
            end
            FILT: begin
                inicio  = 1'b1;
                state_d = WRITE;
            end
            BRD_RD: begin
                rd_en   = 1'b1;
                rd_addr = pix_addr(src_q, addr_t'(x_q), addr_t'(y_q));
                state_d = BRD_WAIT;
            end
            BRD_WAIT: begin
                brd_d   = bus.rd_data;
                state_d = WRITE;
            end
            WRITE: begin
                wr_en   = 1'b1;
                wr_addr = pix_addr(dst_q, addr_t'(x_q), addr_t'(y_q));
                wr_data = interior ? (filt_vld ? filt_pix : 8'd0) : brd_q;
                k_d     = '0;
                if (x_q == X_LAST) begin
                    x_d = '0;
                    if (y_q == Y_LAST) begin
                        state_d = DONE;
                    end else begin
                        y_d     = y_q + 1'b1;
                        state_d = BRD_RD;
                    end
                end else begin
                    x_d     = x_q + 1'b1;
                    state_d = is_interior(x_q + 1'b1, y_q) ? FETCH : BRD_RD;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            k_q     <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            brd_q   <= '0;
            for (int i = 0; i < WIN_TAPS; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            k_q     <= k_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            brd_q   <= brd_d;
            for (int i = 0; i < WIN_TAPS; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    gaussian_filter #(.DATA_W(8)) u_filter (
        .clk             (clk),
        .rst             (rst),
        .inicio          (inicio),
        .pixel_00        (win_q[0]),
        .pixel_01        (win_q[1]),
        .pixel_02        (win_q[2]),
        .pixel_10        (win_q[3]),
        .pixel_11        (win_q[4]),
        .pixel_12        (win_q[5]),
        .pixel_20        (win_q[6]),
        .pixel_21        (win_q[7]),
        .pixel_22        (win_q[8]),
        .pixel_procesado (filt_pix),
        .listo           (filt_vld)
    );

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.rd_en   = rd_en;
    assign bus.rd_addr = rd_addr;
    assign bus.wr_en   = wr_en;
    assign bus.wr_addr = wr_addr;
    assign bus.wr_data = wr_data;
endmodule

// File: tb/tb_gauss_scan_ctrl.sv
// Directed bench for gauss_scan_ctrl: 4x4, 5x5 and 3x3 instances share one byte RAM model.
`timescale 1ns/1ps
module tb_gauss_scan_ctrl;
    import gauss_ctrl_pkg::*;

    localparam int LOG_N = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gauss_scan_ctrl_if #(.ADDR_W(16)) if4 ();
    gauss_scan_ctrl_if #(.ADDR_W(16)) if5 ();
    gauss_scan_ctrl_if #(.ADDR_W(16)) if3 ();

    gauss_scan_ctrl #(.ADDR_W(16), .IMG_W(4), .IMG_H(4)) u_d4 (.clk(clk), .rst(rst), .bus(if4.master));
    gauss_scan_ctrl #(.ADDR_W(16), .IMG_W(5), .IMG_H(5)) u_d5 (.clk(clk), .rst(rst), .bus(if5.master));
    gauss_scan_ctrl #(.ADDR_W(16), .IMG_W(3), .IMG_H(3)) u_d3 (.clk(clk), .rst(rst), .bus(if3.master));

    logic [7:0]  mem [0:65535];
    logic [7:0]  rd_q = 8'd0;
    assign if4.rd_data = rd_q;
    assign if5.rd_data = rd_q;
    assign if3.rd_data = rd_q;

    logic        any_rd, any_wr;
    logic [15:0] rd_a, wr_a;
    logic [7:0]  wr_d;
    always_comb begin
        any_rd = if4.rd_en | if5.rd_en | if3.rd_en;
        any_wr = if4.wr_en | if5.wr_en | if3.wr_en;
        rd_a   = if4.rd_en ? if4.rd_addr : (if5.rd_en ? if5.rd_addr : if3.rd_addr);
        wr_a   = if4.wr_en ? if4.wr_addr : (if5.wr_en ? if5.wr_addr : if3.wr_addr);
        wr_d   = if4.wr_en ? if4.wr_data : (if5.wr_en ? if5.wr_data : if3.wr_data);
    end

    logic [15:0] wlog_a [LOG_N];
    logic [7:0]  wlog_d [LOG_N];
    logic [15:0] rlog_a [LOG_N];
    int wcount = 0, rcount = 0, dcount = 0, clash = 0;

    always @(posedge clk) begin
        if (any_rd) begin
            rd_q <= mem[rd_a];
            if (rcount < LOG_N) rlog_a[rcount] <= rd_a;
            rcount <= rcount + 1;
        end
        if (any_wr) begin
            if (wcount < LOG_N) begin
                wlog_a[wcount] <= wr_a;
                wlog_d[wcount] <= wr_d;
            end
            wcount <= wcount + 1;
        end
        if ((if4.rd_en && if4.wr_en) || (if5.rd_en && if5.wr_en) || (if3.rd_en && if3.wr_en))
            clash <= clash + 1;
        dcount <= dcount + int'(if4.done) + int'(if5.done) + int'(if3.done);
    end

    int checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        int         tid;
        logic [7:0] src;
        logic [7:0] exp;
    } vec_t;
    vec_t vt[$];

    function automatic void add_vec(input int tid, input logic [7:0] s, input logic [7:0] e);
        vec_t v;
        v.tid = tid;
        v.src = s;
        v.exp = e;
        vt.push_back(v);
    endfunction

    task automatic load_img(input int tid, input logic [15:0] sb);
        logic [15:0] a;
        a = sb;
        foreach (vt[i]) begin
            if (vt[i].tid == tid) begin
                mem[a] = vt[i].src;
                a = a + 16'd1;
            end
        end
    endtask

    task automatic check_frame(input int tid, input int wbase, input logic [15:0] db, input string tag);
        int k;
        logic [15:0] a;
        k = 0;
        a = db;
        foreach (vt[i]) begin
            if (vt[i].tid == tid) begin
                if (wbase + k < LOG_N) begin
                    chk($sformatf("%s_addr%0d", tag, k), 32'(wlog_a[wbase + k]), 32'(a));
                    chk($sformatf("%s_px%0d", tag, k), 32'(wlog_d[wbase + k]), 32'(vt[i].exp));
                end
                k++;
                a = a + 16'd1;
            end
        end
        chk({tag, "_wr_count"}, wcount - wbase, k);
    endtask

    task automatic drive_start(input int sel, input logic s, input logic [15:0] sb, input logic [15:0] db);
        case (sel)
            0: begin if4.start = s; if4.src_base = sb; if4.dst_base = db; end
            1: begin if5.start = s; if5.src_base = sb; if5.dst_base = db; end
            default: begin if3.start = s; if3.src_base = sb; if3.dst_base = db; end
        endcase
    endtask

    function automatic logic get_done(input int sel);
        case (sel)
            0: return if4.done;
            1: return if5.done;
            default: return if3.done;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            0: return if4.busy;
            1: return if5.busy;
            default: return if3.busy;
        endcase
    endfunction

    // Pulses start, waits for done (bounded) and returns cycles from the first processing cycle.
    task automatic run_frame(input int sel, input logic [15:0] sb, input logic [15:0] db,
                             input int restart_at, input string tag, output int cyc);
        int n;
        logic seen;
        drive_start(sel, 1'b1, sb, db);
        @(posedge clk); #1;
        drive_start(sel, 1'b0, sb, db);
        chk({tag, "_busy_rise"}, 32'(get_busy(sel)), 32'd1);
        n = 0;
        seen = get_done(sel);
        while (!seen && n < 2000) begin
            if (n == restart_at) drive_start(sel, 1'b1, 16'h0600, 16'h0700);
            @(posedge clk); #1;
            drive_start(sel, 1'b0, sb, db);
            n++;
            seen = get_done(sel);
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: no done after %0d cycles", tag, n);
            cyc = -1;
        end else begin
            cyc = n;
            chk({tag, "_busy_at_done"}, 32'(get_busy(sel)), 32'd1);
        end
        @(posedge clk); #1;
        chk({tag, "_busy_fall"}, 32'(get_busy(sel)), 32'd0);
        chk({tag, "_done_fall"}, 32'(get_done(sel)), 32'd0);
    endtask

    initial begin
        int cyc, wb, db0, rb;
        logic [7:0] ws [9];
        logic [7:0] e5;

        // t1: 4x4 flat 100; t2: 5x5 impulse; t3: 3x3 saturated; t4: 3x3 wrap ramp
        for (int i = 0; i < 16; i++) add_vec(1, 8'd100, 8'd100);
        for (int i = 0; i < 25; i++) begin
            case (i)
                12:              e5 = 8'd40;
                7, 11, 13, 17:   e5 = 8'd20;
                6, 8, 16, 18:    e5 = 8'd10;
                default:         e5 = 8'd0;
            endcase
            add_vec(2, (i == 12) ? 8'd160 : 8'd0, e5);
        end
        for (int i = 0; i < 9; i++) add_vec(3, 8'd255, 8'd255);
        ws = '{8'd16, 8'd32, 8'd48, 8'd64, 8'd80, 8'd96, 8'd112, 8'd128, 8'd255};
        for (int i = 0; i < 9; i++) add_vec(4, ws[i], (i == 4) ? 8'd86 : ws[i]);

        for (int s = 0; s < 3; s++) drive_start(s, 1'b0, 16'h0000, 16'h0000);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",    32'(if4.busy),    32'd0);
        chk("rst_done",    32'(if4.done),    32'd0);
        chk("rst_rd_en",   32'(if4.rd_en),   32'd0);
        chk("rst_wr_en",   32'(if4.wr_en),   32'd0);
        chk("rst_rd_addr", 32'(if4.rd_addr), 32'd0);
        chk("rst_wr_addr", 32'(if4.wr_addr), 32'd0);
        chk("rst_wr_data", 32'(if4.wr_data), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 4x4 flat image
        load_img(1, 16'h0000);
        wb = wcount; db0 = dcount;
        run_frame(0, 16'h0000, 16'h0100, -1, "t1", cyc);
        chk("t1_done_latency", cyc, 4 * INTERIOR_CYCLES + 12 * BORDER_CYCLES);
        check_frame(1, wb, 16'h0100, "t1");
        chk("t1_done_count", dcount - db0, 1);

        // reset during FETCH of pixel (1,1)
        wb = wcount;
        drive_start(0, 1'b1, 16'h0000, 16'h0100);
        @(posedge clk); #1;
        drive_start(0, 1'b0, 16'h0000, 16'h0100);
        repeat (17) @(posedge clk);
        #1;
        chk("rst_mid_rd_en",   32'(if4.rd_en),   32'd1);
        chk("rst_mid_rd_addr", 32'(if4.rd_addr), 32'h0002);
        chk("rst_mid_writes",  wcount - wb, 5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_busy",  32'(if4.busy),  32'd0);
        chk("rst_mid_rd_en_low", 32'(if4.rd_en), 32'd0);
        chk("rst_mid_wr_en", 32'(if4.wr_en), 32'd0);
        wb = wcount;
        repeat (30) @(posedge clk);
        #1;
        chk("rst_mid_no_writes", wcount - wb, 0);
        chk("rst_mid_idle_busy", 32'(if4.busy), 32'd0);
        wb = wcount;
        run_frame(0, 16'h0000, 16'h0180, -1, "rerun", cyc);
        chk("rerun_done_latency", cyc, 84);
        check_frame(1, wb, 16'h0180, "rerun");

        // 5x5 impulse
        load_img(2, 16'h0200);
        wb = wcount;
        run_frame(1, 16'h0200, 16'h0280, -1, "t2", cyc);
        chk("t2_done_latency", cyc, 9 * 12 + 16 * 3);
        check_frame(2, wb, 16'h0280, "t2");

        // 3x3 all 255
        load_img(3, 16'h0400);
        wb = wcount;
        run_frame(2, 16'h0400, 16'h0500, -1, "t3", cyc);
        chk("t3_done_latency", cyc, 36);
        check_frame(3, wb, 16'h0500, "t3");

        // second start mid-frame must be ignored
        wb = wcount; db0 = dcount;
        run_frame(2, 16'h0400, 16'h0500, 5, "t4", cyc);
        chk("t4_done_latency", cyc, 36);
        check_frame(3, wb, 16'h0500, "t4");
        chk("t4_done_count", dcount - db0, 1);

        // source wraps past 0xFFFF
        load_img(4, 16'hFFFE);
        wb = wcount; rb = rcount;
        run_frame(2, 16'hFFFE, 16'h0600, -1, "t5", cyc);
        chk("t5_rd0", 32'(rlog_a[rb]),     32'h0000FFFE);
        chk("t5_rd1", 32'(rlog_a[rb + 1]), 32'h0000FFFF);
        chk("t5_rd2", 32'(rlog_a[rb + 2]), 32'h00000000);
        check_frame(4, wb, 16'h0600, "t5");

        chk("rd_wr_clash", clash, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
